sumador_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `Sumador` adder instance among `N_REQ` requesters. It sits between client blocks and the adder. It accepts one operand pair per handshake and registers the operands. It then drives the adder and returns a registered sum tagged with the winning requester's index. Throughput is one addition per two clock cycles.

---
 rtl/sumador_rr_arbiter_pkg.sv | 19 +
 rtl/sumador_rr_arbiter_if.sv | 30 +++
 rtl/sumador_rr_arbiter_sumador.sv | 12 +
 rtl/sumador_rr_arbiter.sv | 109 ++++++++++
 tb/tb_sumador_rr_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/sumador_rr_arbiter_pkg.sv
// Shared definitions for the round-robin adder arbiter: FSM states,
// default operand width and an elaboration-time clog2 helper.
package sumador_pkg;

  localparam int BITS_DEFAULT = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sumador_rr_arbiter_if.sv
// Requester-side bundle of the shared adder: packed request operands,
// one-hot grant and response pulse, registered tagged result.
interface sumador_rr_arbiter_if
  import sumador_pkg::*;
#(
  parameter int bits  = BITS_DEFAULT,
  parameter int N_REQ = 4
);
  localparam int ID_W = clog2(N_REQ);

  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*bits-1:0] req_a;
  logic [N_REQ*bits-1:0] req_b;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ-1:0]      rsp_valid;
  logic [bits-1:0]       rsp_r;
  logic [ID_W-1:0]       rsp_id;
  logic                  busy;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_r, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_r, rsp_id, busy
  );

endinterface

// File: rtl/sumador_rr_arbiter_sumador.sv
// Plain unsigned adder; the carry out is dropped so R wraps modulo 2^bits.
module Sumador #(
  parameter int bits = 16
) (
  input  logic [bits-1:0] A,
  input  logic [bits-1:0] B,
  output logic [bits-1:0] R
);

  assign R = A + B;

endmodule

// File: rtl/sumador_rr_arbiter.sv
// Round-robin sequencer sharing one Sumador among N_REQ requesters:
// grant in IDLE, add in BUSY, one registered tagged result per two cycles.
module sumador_rr_arbiter
  import sumador_pkg::*;
#(
  parameter int bits  = BITS_DEFAULT,
  parameter int N_REQ = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  sumador_rr_arbiter_if.slave  bus
);

  localparam int              ID_W    = clog2(N_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE    = {{(N_REQ-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   gnt_id;
  logic              gnt_found;
  logic              hs;
  logic [N_REQ-1:0]  ready_c;

  logic [bits-1:0]   op_a_p0, op_b_p0;
  logic [ID_W-1:0]   cur_id_p0;
  logic [bits-1:0]   sum_p0;

  logic [N_REQ-1:0]  rsp_valid_p1;
  logic [bits-1:0]   rsp_r_p1;
  logic [ID_W-1:0]   rsp_id_p1;

  // Search upward from the requester after the last winner, wrapping to 0.
  always_comb begin : rr_search
    int idx;
    gnt_found = 1'b0;
    gnt_id    = last_grant;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(last_grant) + i) % N_REQ;
      if (!gnt_found && bus.req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(idx);
      end
    end
  end

  // Reset masks the grant so a request seen during reset is never latched.
  always_comb begin
    state_d = state_q;
    ready_c = '0;
    hs      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!reset && gnt_found) begin
          ready_c = ONE << gnt_id;
          hs      = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage 0: operands captured on the handshake edge.
  always_ff @(posedge clk) begin
    if (hs) begin
      op_a_p0 <= bus.req_a[int'(gnt_id)*bits +: bits];
      op_b_p0 <= bus.req_b[int'(gnt_id)*bits +: bits];
    end
  end

  Sumador #(.bits(bits)) u_sumador (
    .A(op_a_p0),
    .B(op_b_p0),
    .R(sum_p0)
  );

  // Stage 1: registered result, tag and single-cycle response pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant   <= LAST_ID;
      cur_id_p0    <= '0;
      rsp_valid_p1 <= '0;
      rsp_r_p1     <= '0;
      rsp_id_p1    <= '0;
    end else begin
      state_q      <= state_d;
      rsp_valid_p1 <= '0;
      if (hs) begin
        last_grant <= gnt_id;
        cur_id_p0  <= gnt_id;
      end
      if (state_q == ST_BUSY) begin
        rsp_valid_p1 <= ONE << cur_id_p0;
        rsp_r_p1     <= sum_p0;
        rsp_id_p1    <= cur_id_p0;
      end
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.rsp_valid = rsp_valid_p1;
  assign bus.rsp_r     = rsp_r_p1;
  assign bus.rsp_id    = rsp_id_p1;
  assign bus.busy      = (state_q == ST_BUSY);

endmodule

// File: tb/tb_sumador_rr_arbiter.sv
// Bench for sumador_rr_arbiter: directed scenarios plus a random soak scored
// against a queue-based model of grant order, latency and modulo sums.
module tb_sumador_rr_arbiter;

  localparam int BITS = 16;
  localparam int NR   = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sumador_rr_arbiter_if #(.bits(BITS), .N_REQ(NR)) bus ();

  sumador_rr_arbiter #(.bits(BITS), .N_REQ(NR)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int          due;
    int          id;
    logic [15:0] r;
  } rsp_t;

  task automatic present(input int k, input logic [15:0] a, input logic [15:0] b);
    bus.req_valid[k]         = 1'b1;
    bus.req_a[k*BITS +: BITS] = a;
    bus.req_b[k*BITS +: BITS] = b;
  endtask

  task automatic clear_all();
    bus.req_valid = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_all();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid = '1;
    for (int k = 0; k < NR; k++) present(k, 16'(7 + k), 16'(9 + k));
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
      checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
      checks++; if (bus.rsp_valid !== 4'b0000) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0000", bus.rsp_valid); end
      checks++; if (bus.rsp_r !== 16'd0) begin failures++; $display("FAIL reset_rsp_r got=%0h exp=0", bus.rsp_r); end
      checks++; if (bus.rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%0d exp=0", bus.rsp_id); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL reset_first_grant got=%b exp=0001", bus.req_ready); end
    @(negedge clk);
    clear_all();
    #1;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL reset_busy_after_grant got=%b exp=1", bus.busy); end
    @(negedge clk); #1;
    checks++; if (bus.rsp_valid !== 4'b0001) begin failures++; $display("FAIL reset_first_rsp_valid got=%b exp=0001", bus.rsp_valid); end
    checks++; if (bus.rsp_r !== 16'd16) begin failures++; $display("FAIL reset_first_rsp_r got=%0d exp=16", bus.rsp_r); end
  endtask

  task automatic test_single();
    @(negedge clk);
    present(2, 16'd100, 16'd23);
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", bus.req_ready); end
    @(negedge clk);
    clear_all();
    #1;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
    checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL single_ready_busy got=%b exp=0000", bus.req_ready); end
    @(negedge clk); #1;
    checks++; if (bus.rsp_valid !== 4'b0100) begin failures++; $display("FAIL single_rsp_valid got=%b exp=0100", bus.rsp_valid); end
    checks++; if (bus.rsp_id !== 2'd2) begin failures++; $display("FAIL single_rsp_id got=%0d exp=2", bus.rsp_id); end
    checks++; if (bus.rsp_r !== 16'd123) begin failures++; $display("FAIL single_rsp_r got=%0d exp=123", bus.rsp_r); end
    @(negedge clk); #1;
    checks++; if (bus.rsp_valid !== 4'b0000) begin failures++; $display("FAIL single_pulse_width got=%b exp=0000", bus.rsp_valid); end
    checks++; if (bus.rsp_r !== 16'd123) begin failures++; $display("FAIL single_rsp_hold got=%0d exp=123", bus.rsp_r); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    present(1, 16'hFFFF, 16'h0002);
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL wrap_ready got=%b exp=0010", bus.req_ready); end
    @(negedge clk);
    clear_all();
    @(negedge clk); #1;
    checks++; if (bus.rsp_valid !== 4'b0010) begin failures++; $display("FAIL wrap_rsp_valid got=%b exp=0010", bus.rsp_valid); end
    checks++; if (bus.rsp_r !== 16'h0001) begin failures++; $display("FAIL wrap_rsp_r got=%0h exp=1", bus.rsp_r); end
    checks++; if (bus.rsp_id !== 2'd1) begin failures++; $display("FAIL wrap_rsp_id got=%0d exp=1", bus.rsp_id); end
  endtask

  task automatic test_contention();
    int id;
    logic [3:0] exp_v;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      exp_v = 4'b0000;
      id = 0;
      if (c >= 2 && (c % 2) == 0) begin
        id = ((c - 2) / 2) % NR;
        exp_v = 4'(1 << id);
      end
      checks++; if (bus.rsp_valid !== exp_v) begin failures++; $display("FAIL contention_rsp_valid c=%0d got=%b exp=%b", c, bus.rsp_valid, exp_v); end
      if (exp_v != 4'b0000) begin
        checks++; if (bus.rsp_id !== 2'(id)) begin failures++; $display("FAIL contention_rsp_id c=%0d got=%0d exp=%0d", c, bus.rsp_id, id); end
        checks++; if (bus.rsp_r !== 16'(11 * id)) begin failures++; $display("FAIL contention_rsp_r c=%0d got=%0d exp=%0d", c, bus.rsp_r, 11 * id); end
      end
      if (c == 0) for (int k = 0; k < NR; k++) present(k, 16'(k), 16'(10 * k));
      #1;
      exp_v = ((c % 2) == 0) ? 4'(1 << ((c / 2) % NR)) : 4'b0000;
      checks++; if (bus.req_ready !== exp_v) begin failures++; $display("FAIL contention_ready c=%0d got=%b exp=%b", c, bus.req_ready, exp_v); end
    end
    @(negedge clk);
    clear_all();
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    present(3, 16'd40, 16'd2);
    #1;
    checks++; if (bus.req_ready !== 4'b1000) begin failures++; $display("FAIL midreset_ready got=%b exp=1000", bus.req_ready); end
    @(negedge clk);
    clear_all();
    reset = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL midreset_busy got=%b exp=1", bus.busy); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 4'b0000) begin failures++; $display("FAIL midreset_no_rsp got=%b exp=0000", bus.rsp_valid); end
    checks++; if (bus.rsp_r !== 16'd0) begin failures++; $display("FAIL midreset_rsp_r got=%0d exp=0", bus.rsp_r); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midreset_idle got=%b exp=0", bus.busy); end
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 4'b0000) begin failures++; $display("FAIL midreset_no_late_rsp got=%b exp=0000", bus.rsp_valid); end
    present(0, 16'd1, 16'd1);
    present(3, 16'd2, 16'd2);
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL midreset_next_grant got=%b exp=0001", bus.req_ready); end
    @(negedge clk);
    clear_all();
  endtask

  task automatic test_random_soak();
    localparam int SOAK = 200;
    rsp_t        q[$];
    rsp_t        e;
    bit          pend[NR];
    logic [15:0] pa[NR], pb[NR];
    int          start[NR];
    int          last_g, last_hs, g, k, exp_id;
    logic [15:0] exp_r;
    logic [3:0]  exp_v, exp_rdy;
    do_reset();
    for (int i = 0; i < NR; i++) begin pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; start[i] = 0; end
    last_g = NR - 1; last_hs = -10; exp_r = '0; exp_id = 0;
    for (int cyc = 0; cyc < SOAK + 40; cyc++) begin
      @(negedge clk);
      exp_v = 4'b0000;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        exp_v = 4'(1 << e.id);
        exp_r = e.r;
        exp_id = e.id;
      end
      checks++; if (bus.rsp_valid !== exp_v) begin failures++; $display("FAIL soak_rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, exp_v); end
      checks++; if (bus.rsp_r !== exp_r) begin failures++; $display("FAIL soak_rsp_r cyc=%0d got=%0h exp=%0h", cyc, bus.rsp_r, exp_r); end
      checks++; if (bus.rsp_id !== 2'(exp_id)) begin failures++; $display("FAIL soak_rsp_id cyc=%0d got=%0d exp=%0d", cyc, bus.rsp_id, exp_id); end
      checks++; if (bus.busy !== (cyc == last_hs + 1)) begin failures++; $display("FAIL soak_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, cyc == last_hs + 1); end
      for (int j = 0; j < NR; j++) begin
        if (!pend[j] && cyc < SOAK && $urandom_range(0, 99) < 45) begin
          pend[j] = 1'b1;
          pa[j] = 16'($urandom);
          pb[j] = 16'($urandom);
          start[j] = cyc;
        end
        bus.req_valid[j] = pend[j];
        bus.req_a[j*BITS +: BITS] = pa[j];
        bus.req_b[j*BITS +: BITS] = pb[j];
      end
      #1;
      g = -1;
      if (cyc != last_hs + 1) begin
        for (int i = 1; i <= NR; i++) begin
          k = (last_g + i) % NR;
          if (g < 0 && pend[k]) g = k;
        end
      end
      exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
      checks++; if (bus.req_ready !== exp_rdy) begin failures++; $display("FAIL soak_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_rdy); end
      if (g >= 0) begin
        e.due = cyc + 2;
        e.id  = g;
        e.r   = pa[g] + pb[g];
        q.push_back(e);
        checks++; if (cyc - start[g] > 2 * NR) begin failures++; $display("FAIL soak_fairness id=%0d waited=%0d max=%0d", g, cyc - start[g], 2 * NR); end
        pend[g] = 1'b0;
        last_g = g;
        last_hs = cyc;
      end
    end
    checks++; if (q.size() != 0) begin failures++; $display("FAIL soak_drain outstanding=%0d exp=0", q.size()); end
    clear_all();
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    test_reset();
    test_single();
    test_wrap();
    test_contention();
    test_reset_mid();
    test_random_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
